// File: rtl/vga_scan_generator.sv
// 640x480@60 Hz raster scan generator: prescaled pixel counters with registered
// sync/blanking decode so every output changes on the same edge as xpix/ypix.
module vga_scan_generator #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] xpix,
  output logic [9:0] ypix,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);

  logic [1:0] div_cnt;
  logic       adv;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;

  // With CLK_DIV = 1 DIV_LAST is 0, so adv stays high every cycle.
  assign adv = (div_cnt == DIV_LAST);

  always_comb begin
    x_nxt = xpix + 10'd1;
    y_nxt = ypix;
    if (xpix == H_LAST) begin
      x_nxt = '0;
      y_nxt = (ypix == V_LAST) ? '0 : ypix + 10'd1;
    end
  end

  // Reset parks the counters on the last pixel so the first advance lands on
  // (0, 0) and the first frame is complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      xpix        <= H_LAST;
      ypix        <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= adv ? 2'd0 : div_cnt + 2'd1;
      pix_tick    <= adv;
      line_start  <= adv && (x_nxt == 10'd0);
      frame_start <= adv && (x_nxt == 10'd0) && (y_nxt == 10'd0);
      if (adv) begin
        xpix     <= x_nxt;
        ypix     <= y_nxt;
        hsync    <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
        vsync    <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
        video_on <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator: a default-timing instance plus two shrunken-timing
// instances (CLK_DIV 1 and 3) checked every cycle against a pixel-index model.
module tb_vga_scan_generator;

  // Instance 0: defaults. Instances 1/2: tiny raster so whole frames fit the run.
  localparam int DIV[3] = '{2, 1, 3};
  localparam int HV[3]  = '{640, 8, 8};
  localparam int HF[3]  = '{16, 2, 2};
  localparam int HS[3]  = '{96, 3, 3};
  localparam int HB[3]  = '{48, 2, 2};
  localparam int VV[3]  = '{480, 5, 5};
  localparam int VF[3]  = '{10, 1, 1};
  localparam int VS[3]  = '{2, 2, 2};
  localparam int VB[3]  = '{33, 1, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] xp[3];
  logic [9:0] yp[3];
  logic       hs[3], vs[3], vo[3], pt[3], ls[3], fs[3];

  int     n_pass = 0;
  int     n_total = 0;
  longint kcnt;
  bit     cmp_en = 1'b0;

  always #5 clk = ~clk;

  vga_scan_generator dut0 (
    .clk(clk), .reset(reset), .xpix(xp[0]), .ypix(yp[0]), .hsync(hs[0]), .vsync(vs[0]),
    .video_on(vo[0]), .pix_tick(pt[0]), .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_scan_generator #(
    .CLK_DIV(DIV[1]), .H_VISIBLE(HV[1]), .H_FRONT(HF[1]), .H_SYNC(HS[1]), .H_BACK(HB[1]),
    .V_VISIBLE(VV[1]), .V_FRONT(VF[1]), .V_SYNC(VS[1]), .V_BACK(VB[1])
  ) dut1 (
    .clk(clk), .reset(reset), .xpix(xp[1]), .ypix(yp[1]), .hsync(hs[1]), .vsync(vs[1]),
    .video_on(vo[1]), .pix_tick(pt[1]), .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_scan_generator #(
    .CLK_DIV(DIV[2]), .H_VISIBLE(HV[2]), .H_FRONT(HF[2]), .H_SYNC(HS[2]), .H_BACK(HB[2]),
    .V_VISIBLE(VV[2]), .V_FRONT(VF[2]), .V_SYNC(VS[2]), .V_BACK(VB[2])
  ) dut2 (
    .clk(clk), .reset(reset), .xpix(xp[2]), .ypix(yp[2]), .hsync(hs[2]), .vsync(vs[2]),
    .video_on(vo[2]), .pix_tick(pt[2]), .line_start(ls[2]), .frame_start(fs[2])
  );

  // Clock edges seen since reset was released.
  always @(posedge clk or posedge reset) begin
    if (reset) kcnt <= 0;
    else       kcnt <= kcnt + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // After k edges the scan has advanced floor(k/DIV) times; advance n shows
  // raster pixel index n-1 (row-major), so everything follows from that index.
  function automatic void model(input int i, input longint k,
                                output int ex, output int ey, output int ehs, output int evs,
                                output int evo, output int ept, output int els, output int efs);
    int     ht, vt;
    longint a, p;
    ht = HV[i] + HF[i] + HS[i] + HB[i];
    vt = VV[i] + VF[i] + VS[i] + VB[i];
    a  = k / DIV[i];
    if (a == 0) begin
      ex = ht - 1; ey = vt - 1; ehs = 1; evs = 1; evo = 0; ept = 0; els = 0; efs = 0;
    end else begin
      p   = (a - 1) % (ht * vt);
      ex  = int'(p % ht);
      ey  = int'(p / ht);
      ehs = (ex >= HV[i] + HF[i] && ex < HV[i] + HF[i] + HS[i]) ? 0 : 1;
      evs = (ey >= VV[i] + VF[i] && ey < VV[i] + VF[i] + VS[i]) ? 0 : 1;
      evo = (ex < HV[i] && ey < VV[i]) ? 1 : 0;
      ept = (k % DIV[i] == 0) ? 1 : 0;
      els = (ept == 1 && ex == 0) ? 1 : 0;
      efs = (ept == 1 && p == 0) ? 1 : 0;
    end
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        int ex, ey, ehs, evs, evo, ept, els, efs;
        model(i, reset ? 64'd0 : kcnt, ex, ey, ehs, evs, evo, ept, els, efs);
        chk($sformatf("m%0d_xpix", i), int'(xp[i]), ex);
        chk($sformatf("m%0d_ypix", i), int'(yp[i]), ey);
        chk($sformatf("m%0d_hsync", i), int'(hs[i]), ehs);
        chk($sformatf("m%0d_vsync", i), int'(vs[i]), evs);
        chk($sformatf("m%0d_video_on", i), int'(vo[i]), evo);
        chk($sformatf("m%0d_pix_tick", i), int'(pt[i]), ept);
        chk($sformatf("m%0d_line_start", i), int'(ls[i]), els);
        chk($sformatf("m%0d_frame_start", i), int'(fs[i]), efs);
        chk($sformatf("m%0d_x_range", i), int'(xp[i] < 10'(HV[i] + HF[i] + HS[i] + HB[i])), 1);
        chk($sformatf("m%0d_y_range", i), int'(yp[i] < 10'(VV[i] + VF[i] + VS[i] + VB[i])), 1);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_x"}, int'(xp[0]), 799);
    chk({tag, "_y"}, int'(yp[0]), 524);
    chk({tag, "_hsync"}, int'(hs[0]), 1);
    chk({tag, "_vsync"}, int'(vs[0]), 1);
    chk({tag, "_video_on"}, int'(vo[0]), 0);
    chk({tag, "_frame_start"}, int'(fs[0]), 0);
  endtask

  task automatic release_and_check_start(input string tag);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, "_x0"}, int'(xp[0]), 0);
    chk({tag, "_y0"}, int'(yp[0]), 0);
    chk({tag, "_fs"}, int'(fs[0]), 1);
    chk({tag, "_ls"}, int'(ls[0]), 1);
    chk({tag, "_vo"}, int'(vo[0]), 1);
    chk({tag, "_hs"}, int'(hs[0]), 1);
    chk({tag, "_vs"}, int'(vs[0]), 1);
    @(negedge clk);
    chk({tag, "_fs_drop"}, int'(fs[0]), 0);
  endtask

  // Waits for an event on instance 0; sel picks the condition. Timeout counts as a failure.
  task automatic wait_ev(input int sel, input int lim, output longint t);
    bit hit;
    hit = 1'b0;
    t   = -1;
    for (int n = 0; n < lim && !hit; n++) begin
      @(negedge clk);
      case (sel)
        0: hit = (vo[0] == 1'b0);
        1: hit = (hs[0] == 1'b0);
        2: hit = (hs[0] == 1'b1);
        3: hit = (ls[0] == 1'b1);
        4: hit = (xp[0] == 10'd300 && yp[0] == 10'd2);
        default: hit = (xp[0] == 10'd700);
      endcase
    end
    if (hit) t = kcnt;
    else chk($sformatf("timeout_ev%0d", sel), 0, 1);
  endtask

  initial begin
    longint t_vo, t_hf, t_hr, t_ls;
    longint fs_t[3][2];
    int     fs_n[3], vs_low[3], pt_low1, vo_bad;

    reset = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("rst");
    release_and_check_start("start");

    // One line of instance 0 (line_start was at edge 2).
    wait_ev(0, 2000, t_vo);
    chk("vo_fall_clk", int'(t_vo - 2), 1280);
    chk("vo_fall_x", int'(xp[0]), 640);
    wait_ev(1, 2000, t_hf);
    chk("hs_fall_clk", int'(t_hf - 2), 1312);
    chk("hs_fall_x", int'(xp[0]), 656);
    wait_ev(2, 2000, t_hr);
    chk("hs_low_len", int'(t_hr - t_hf), 192);
    chk("hs_rise_x", int'(xp[0]), 752);
    wait_ev(3, 2000, t_ls);
    chk("line_period", int'(t_ls - 2), 1600);
    chk("line2_y", int'(yp[0]), 1);

    // Whole frames of the small instances.
    for (int i = 0; i < 3; i++) begin
      fs_n[i] = 0; vs_low[i] = 0;
      fs_t[i][0] = 0; fs_t[i][1] = 0;
    end
    pt_low1 = 0;
    vo_bad  = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      for (int i = 1; i < 3; i++) begin
        if (fs[i]) begin
          if (fs_n[i] < 2) fs_t[i][fs_n[i]] = kcnt;
          if (fs_n[i] < 2) begin
            chk($sformatf("wrap%0d_vo", i), int'(vo[i]), 1);
            chk($sformatf("wrap%0d_xy", i), int'(xp[i]) + int'(yp[i]), 0);
          end
          fs_n[i]++;
        end
        if (fs_n[i] == 1 && !vs[i]) vs_low[i]++;
        if (vo[i] && yp[i] >= 10'd5) vo_bad++;
      end
      if (!pt[1]) pt_low1++;
    end
    chk("d1_frame_period", int'(fs_t[1][1] - fs_t[1][0]), 135);
    chk("d3_frame_period", int'(fs_t[2][1] - fs_t[2][0]), 405);
    chk("d1_vsync_low", vs_low[1], 30);
    chk("d3_vsync_low", vs_low[2], 90);
    chk("d1_tick_gaps", pt_low1, 0);
    chk("vo_in_vblank", vo_bad, 0);

    // Mid-line reset at (300, 2): coordinates jump straight to the parked position.
    wait_ev(4, 6000, t_ls);
    #2 reset = 1'b1;
    #1 check_reset_vals("midrst");
    repeat (2) @(posedge clk);
    release_and_check_start("restart");

    // Reset inside the hsync pulse drops sync to inactive at once.
    wait_ev(5, 2000, t_ls);
    chk("pre_rst_hs_low", int'(hs[0]), 0);
    #2 reset = 1'b1;
    #1 chk("rst_hs_release", int'(hs[0]), 1);
    check_reset_vals("syncrst");
    repeat (2) @(posedge clk);
    release_and_check_start("restart2");
    repeat (200) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
